// File: rtl/mc_rfr_seq_if.sv
// Refresh sequencer bus: refresh timer handshake, controller idle status,
// refresh configuration and the SDRAM command outputs.
// master: the side that raises requests and observes commands.
// slave:  the refresh sequencer itself.
interface mc_rfr_seq_if #(
  parameter int NCS = 8
);
  logic           rfr_req;
  logic           rfr_ack;
  logic           mem_idle;
  logic           rfr_busy;
  logic [NCS-1:0] cs_need_rfr;
  logic [3:0]     trp;
  logic [3:0]     trfc;
  logic [1:0]     rfr_burst;
  logic [NCS-1:0] cs_n;
  logic [2:0]     cmd;
  logic           a10;

  modport master (
    output rfr_req, mem_idle, cs_need_rfr, trp, trfc, rfr_burst,
    input  rfr_ack, rfr_busy, cs_n, cmd, a10
  );

  modport slave (
    input  rfr_req, mem_idle, cs_need_rfr, trp, trfc, rfr_burst,
    output rfr_ack, rfr_busy, cs_n, cmd, a10
  );
endinterface

// File: rtl/mc_rfr_seq.sv
// SDRAM refresh command sequencer. Waits for a refresh request while the
// controller is idle, acknowledges it, takes the command bus and issues
// (optionally) PRECHARGE-ALL followed by 1..4 AUTO REFRESH commands on
// every selected chip, with tRP/tRFC NOP spacing, then releases the bus.
// Optional feature macro: MC_RFR_PRE_EN (enables PRECHARGE-ALL + tRP wait).
// All outputs are registered; they are derived from the next state so they
// line up with the state they describe.
module mc_rfr_seq #(
  parameter int NCS = 8
) (
  input logic         clk,
  input logic         rst,
  mc_rfr_seq_if.slave bus
);

  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_PRE  = 3'b010;
  localparam logic [2:0] CMD_AREF = 3'b001;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    PRE,
    PRE_WAIT,
    REF,
    REF_WAIT
  } state_t;

  state_t         state_reg, state_next;
  logic [NCS-1:0] mask_reg, mask_next;
  logic [2:0]     rem_reg, rem_next;      // AUTO REFRESH commands still to issue
  logic [3:0]     timer_reg, timer_next;  // NOP cycles left in the current wait
  logic [3:0]     trfc_reg, trfc_next;

  logic           ack_reg, ack_next;
  logic           busy_reg, busy_next;
  logic [NCS-1:0] cs_n_reg, cs_n_next;
  logic [2:0]     cmd_reg, cmd_next;
  logic           a10_reg, a10_next;

`ifdef MC_RFR_PRE_EN
  logic [3:0]     trp_reg, trp_next;
`else
  // tRP has no meaning when banks are guaranteed closed on entry.
  logic           unused_trp;
  assign unused_trp = ^bus.trp;
`endif

  // State, shadow configuration and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      mask_reg  <= '0;
      rem_reg   <= '0;
      timer_reg <= '0;
      trfc_reg  <= '0;
      ack_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      cs_n_reg  <= '1;
      cmd_reg   <= CMD_NOP;
      a10_reg   <= 1'b0;
`ifdef MC_RFR_PRE_EN
      trp_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      rem_reg   <= rem_next;
      timer_reg <= timer_next;
      trfc_reg  <= trfc_next;
      ack_reg   <= ack_next;
      busy_reg  <= busy_next;
      cs_n_reg  <= cs_n_next;
      cmd_reg   <= cmd_next;
      a10_reg   <= a10_next;
`ifdef MC_RFR_PRE_EN
      trp_reg   <= trp_next;
`endif
    end
  end

  // Next-state logic, counters and next output values.
  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    rem_next   = rem_reg;
    timer_next = timer_reg;
    trfc_next  = trfc_reg;
`ifdef MC_RFR_PRE_EN
    trp_next   = trp_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (bus.rfr_req && bus.mem_idle) begin
          state_next = GRANT;
          // Configuration is frozen for the whole sequence.
          mask_next  = bus.cs_need_rfr;
          rem_next   = {1'b0, bus.rfr_burst} + 3'd1;
          trfc_next  = bus.trfc;
`ifdef MC_RFR_PRE_EN
          trp_next   = bus.trp;
`endif
        end
      end
      GRANT: begin
        if (mask_reg == '0) begin
          state_next = IDLE;  // nothing to refresh; the ack still went out
        end else begin
`ifdef MC_RFR_PRE_EN
          state_next = PRE;
`else
          state_next = REF;
`endif
        end
      end
`ifdef MC_RFR_PRE_EN
      PRE: begin
        state_next = PRE_WAIT;
        timer_next = (trp_reg == 4'd0) ? 4'd1 : trp_reg;
      end
      PRE_WAIT: begin
        if (timer_reg <= 4'd1) state_next = REF;
        else                   timer_next = timer_reg - 4'd1;
      end
`endif
      REF: begin
        state_next = REF_WAIT;
        rem_next   = rem_reg - 3'd1;
        timer_next = (trfc_reg == 4'd0) ? 4'd1 : trfc_reg;
      end
      REF_WAIT: begin
        if (timer_reg <= 4'd1) state_next = (rem_reg != 3'd0) ? REF : IDLE;
        else                   timer_next = timer_reg - 4'd1;
      end
      default: state_next = IDLE;
    endcase

    ack_next  = (state_next == GRANT);
    busy_next = (state_next != IDLE);
    cs_n_next = '1;
    cmd_next  = CMD_NOP;
    a10_next  = 1'b0;
    if (state_next == REF) begin
      cs_n_next = ~mask_next;
      cmd_next  = CMD_AREF;
    end
`ifdef MC_RFR_PRE_EN
    if (state_next == PRE) begin
      cs_n_next = ~mask_next;
      cmd_next  = CMD_PRE;
      a10_next  = 1'b1;  // precharge all banks
    end
`endif
  end

  assign bus.rfr_ack  = ack_reg;
  assign bus.rfr_busy = busy_reg;
  assign bus.cs_n     = cs_n_reg;
  assign bus.cmd      = cmd_reg;
  assign bus.a10      = a10_reg;

endmodule

// File: tb/tb_mc_rfr_seq.sv
// Testbench for mc_rfr_seq. A cycle-level expectation queue is built from
// the documented timing rules whenever a request is accepted, and every
// cycle's outputs are compared against it. Each sequence additionally
// checks ack/command counts and the closed-form busy length.
module tb_mc_rfr_seq;
  localparam int NCS = 8;
`ifdef MC_RFR_PRE_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif

  // {ack, busy, cs_n[7:0], cmd[2:0], a10}
  localparam logic [13:0] IDLE_REC = {1'b0, 1'b0, 8'hFF, 3'b111, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;

  mc_rfr_seq_if #(.NCS(NCS)) bus ();
  mc_rfr_seq #(.NCS(NCS)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  int ack_cnt, busy_cnt, ref_cnt, pre_cnt;

  logic [13:0] exp_q[$];
  logic [13:0] cur_exp;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int max1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic logic [13:0] dut_rec();
    return {bus.rfr_ack, bus.rfr_busy, bus.cs_n, bus.cmd, bus.a10};
  endfunction

  // Expand one accepted request into its cycle-by-cycle output trace.
  task automatic build_seq(input logic [7:0] m, input int tp, input int tf, input int b);
    exp_q.push_back({1'b1, 1'b1, 8'hFF, 3'b111, 1'b0});
    if (m != 8'h00) begin
      if (PRE_EN) begin
        exp_q.push_back({1'b0, 1'b1, ~m, 3'b010, 1'b1});
        for (int i = 0; i < max1(tp); i++) exp_q.push_back({1'b0, 1'b1, 8'hFF, 3'b111, 1'b0});
      end
      for (int k = 0; k <= b; k++) begin
        exp_q.push_back({1'b0, 1'b1, ~m, 3'b001, 1'b0});
        for (int i = 0; i < max1(tf); i++) exp_q.push_back({1'b0, 1'b1, 8'hFF, 3'b111, 1'b0});
      end
    end
  endtask

  // Reference model step at each edge, compare just after it.
  initial begin
    cur_exp = IDLE_REC;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        cur_exp = IDLE_REC;
      end else begin
        if (!cur_exp[12] && bus.rfr_req && bus.mem_idle)
          build_seq(bus.cs_need_rfr, int'(bus.trp), int'(bus.trfc), int'(bus.rfr_burst));
        cur_exp = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE_REC;
      end
      #1;
      if (!rst) begin
        check_val("cycle", 32'(dut_rec()), 32'(cur_exp));
        if (bus.rfr_ack)           ack_cnt++;
        if (bus.rfr_busy)          busy_cnt++;
        if (bus.cmd == 3'b001)     ref_cnt++;
        if (bus.cmd == 3'b010)     pre_cnt++;
      end
    end
  end

  task automatic clear_counts();
    ack_cnt = 0; busy_cnt = 0; ref_cnt = 0; pre_cnt = 0;
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    while (!bus.rfr_ack && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_val("ack_seen", 32'(bus.rfr_ack), 32'd1);
    bus.rfr_req = 1'b0;  // the timer clears its request on ack
  endtask

  // Ride out the sequence while scrambling the (ignored) configuration inputs.
  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.rfr_busy && n < 300) begin
      bus.cs_need_rfr = 8'($urandom);
      bus.trp         = 4'($urandom);
      bus.trfc        = 4'($urandom);
      bus.rfr_burst   = 2'($urandom);
      bus.mem_idle    = 1'($urandom);
      @(negedge clk);
      n++;
    end
    check_val("busy_end", 32'(bus.rfr_busy), 32'd0);
    bus.mem_idle = 1'b1;
  endtask

  task automatic check_totals(input string tag, input logic [7:0] m, input int tp,
                              input int tf, input int b);
    int exp_busy;
    exp_busy = 1;
    if (m != 8'h00) exp_busy = 1 + (PRE_EN ? 1 + max1(tp) : 0) + (b + 1) * (1 + max1(tf));
    check_val({tag, "_acks"}, 32'(ack_cnt), 32'd1);
    check_val({tag, "_busy"}, 32'(busy_cnt), 32'(exp_busy));
    check_val({tag, "_refs"}, 32'(ref_cnt), (m != 8'h00) ? 32'(b + 1) : 32'd0);
    check_val({tag, "_pres"}, 32'(pre_cnt), (m != 8'h00 && PRE_EN) ? 32'd1 : 32'd0);
    $display("[TB] %s mask=%02h trp=%0d trfc=%0d burst=%0d busy=%0d refs=%0d",
             tag, m, tp, tf, b, busy_cnt, ref_cnt);
  endtask

  // Caller is at a negedge with the sequencer idle.
  task automatic run_seq(input string tag, input logic [7:0] m, input int tp,
                         input int tf, input int b, input int block);
    clear_counts();
    bus.cs_need_rfr = m;
    bus.trp         = 4'(tp);
    bus.trfc        = 4'(tf);
    bus.rfr_burst   = 2'(b);
    bus.rfr_req     = 1'b1;
    bus.mem_idle    = (block == 0);
    for (int i = 0; i < block; i++) @(negedge clk);
    if (block != 0) check_val({tag, "_blocked_ack"}, 32'(ack_cnt), 32'd0);
    bus.mem_idle = 1'b1;
    wait_ack();
    wait_idle();
    check_totals(tag, m, tp, tf, b);
  endtask

  initial begin
    int n;
    logic [7:0] rm;
    bus.rfr_req     = 1'b0;
    bus.mem_idle    = 1'b1;
    bus.cs_need_rfr = '0;
    bus.trp         = '0;
    bus.trfc        = '0;
    bus.rfr_burst   = '0;
    clear_counts();
    repeat (3) @(negedge clk);
    check_val("reset_state", 32'(dut_rec()), 32'(IDLE_REC));
    rst = 1'b0;
    @(negedge clk);

    run_seq("basic",   8'h05, 2, 4, 0, 0);
    run_seq("burst",   8'h05, 2, 1, 3, 0);
    run_seq("blocked", 8'hA5, 1, 1, 0, 20);
    run_seq("zero_t",  8'hFF, 0, 0, 1, 0);
    run_seq("mask0",   8'h00, 3, 3, 2, 0);
    run_seq("b2b",     8'h81, 15, 15, 3, 0);

    for (int it = 0; it < 20; it++) begin
      rm = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      run_seq("rand", rm, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of a REF_WAIT, with a request pending.
    clear_counts();
    bus.cs_need_rfr = 8'h3C;
    bus.trp         = 4'd1;
    bus.trfc        = 4'd9;
    bus.rfr_burst   = 2'd1;
    bus.rfr_req     = 1'b1;
    wait_ack();
    n = 0;
    while (bus.cmd != 3'b001 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_val("rst_ref_seen", 32'(bus.cmd), 32'(3'b001));
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.rfr_req = 1'b1;
    #1;
    check_val("async_reset", 32'(dut_rec()), 32'(IDLE_REC));
    @(negedge clk);
    @(negedge clk);
    clear_counts();
    rst = 1'b0;
    wait_ack();
    bus.cs_need_rfr = 8'h3C;  // hold config steady so totals refer to it
    wait_idle();
    check_totals("after_rst", 8'h3C, 1, 9, 1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/mc_rfr_seq.md
# mc_rfr_seq

Refresh command sequencer for the memory controller's SDRAM refresh path. It consumes the refresh request from the refresh timer and waits until the main controller is idle. It then acknowledges the request and takes ownership of the memory command bus. On every chip select that needs refresh, it issues PRECHARGE-ALL followed by one or more AUTO REFRESH commands, with programmable tRP/tRFC spacing, and then returns the bus.

## Interface
Parameters:
- NCS, 8, number of chip selects; width of the mask and `cs_n`.

Ports:
- `clk`  in  1  controller clock.
- `rst`  in  1  reset; asynchronous and active-high.
- `rfr_req`  in  1  refresh request from the refresh timer; held high until acknowledged.
- `rfr_ack`  out  1  one-cycle acknowledge; the timer clears `rfr_req` on it.
- `mem_idle`  in  1  main controller has no access in progress and will start none while `rfr_busy` is high.
- `rfr_busy`  out  1  sequencer owns the SDRAM command bus.
- `cs_need_rfr`  in  NCS  chip selects requiring refresh.
- `trp`  in  4  precharge-to-refresh wait, in cycles.
- `trfc`  in  4  refresh-to-next-command wait, in cycles.
- `rfr_burst`  in  2  number of AUTO REFRESH commands per sequence, minus 1.
- `cs_n`  out  NCS  active-low chip selects driven while `rfr_busy` is high.
- `cmd`  out  3  {ras_n, cas_n, we_n}: NOP=3'b111, PRECHARGE=3'b010, AUTO REFRESH=3'b001.
- `a10`  out  1  address bit 10; high during PRECHARGE (all banks).

## Operation
- All outputs are registered. Reset values: `rfr_ack`=0, `rfr_busy`=0, `cs_n`=all ones, `cmd`=3'b111, `a10`=0, state IDLE, counters 0.
- States and transitions:
  - IDLE → GRANT when `rfr_req` & `mem_idle` are both high.
  - GRANT → PRE, or → REF without MC_RFR_PRE_EN.
  - PRE → PRE_WAIT.
  - PRE_WAIT → REF when the timer expires.
  - REF → REF_WAIT.
  - REF_WAIT → REF when refreshes remain; otherwise → IDLE.
- GRANT actions:
  - Pulse `rfr_ack` and assert `rfr_busy`; `cmd`=NOP.
  - Latch `cs_need_rfr` into the mask, `rfr_burst` into the remaining-refresh counter, and `trp`/`trfc` into shadow registers. Input changes during a sequence have no effect.
- Zero mask at GRANT: ack is still issued, no command is issued, and the state returns directly to IDLE.
- PRE / REF are one-cycle command states. `cs_n` = ~mask, `cmd` is PRECHARGE or AUTO REFRESH, and `a10`=1 in PRE only. In every other state `cs_n` is all ones and `cmd` is NOP.
- Wait timer is a 4-bit down-counter loaded on entry to PRE_WAIT or REF_WAIT. A load value of 0 is treated as 1, so there is at least one NOP.
- The remaining-refresh counter decrements on each REF.
- `rfr_busy` stays high from GRANT through the last REF_WAIT cycle inclusive.
- `rfr_req` high while `mem_idle` is low: stay in IDLE with no ack; the request is held.
- `rfr_req` high again on the cycle the sequence returns to IDLE: a new sequence may start on the following cycle. There is no lockout.
- Reset mid-sequence aborts immediately to reset values. No command is completed.

## Timing
- `rfr_req` & `mem_idle` sampled high at edge N gives:
  - `rfr_ack`=1 and `rfr_busy`=1 in cycle N+1.
  - PRECHARGE in N+2.
  - NOP for max(trp,1) cycles.
  - First AUTO REFRESH in N+3+max(trp,1).
- Each REF is followed by max(trfc,1) NOP cycles. `rfr_busy` falls on the cycle after the last of them.
- Without MC_RFR_PRE_EN, the first REF is in N+2.
- Total busy cycles: 1 + [1+max(trp,1)] + (rfr_burst+1)·(1+max(trfc,1)). The bracketed term applies only with MC_RFR_PRE_EN.

## Configuration
- MC_RFR_PRE_EN defined: each sequence starts with PRECHARGE-ALL and the tRP wait.
- MC_RFR_PRE_EN undefined:
  - PRE and PRE_WAIT are removed, `a10` is tied 0, and `trp` is ignored.
  - The main controller guarantees all banks are closed whenever `mem_idle` is high.

## Test plan
- Basic sequence with MC_RFR_PRE_EN:
  - Stimulus: mask=8'h05, trp=2, trfc=4, burst=0, `rfr_req`/`mem_idle` high at edge 0.
  - Response: ack in cycle 1; PRECHARGE with `cs_n`=8'hFA and a10=1 in cycle 2; REF in cycle 5; `rfr_busy` low in cycle 10.
- Burst:
  - Stimulus: burst=3, trfc=1.
  - Response: 4 REF commands, each separated by exactly 1 NOP; one ack only.
- Blocked request:
  - Stimulus: `rfr_req` high and `mem_idle` low for 20 cycles, then `mem_idle` rises.
  - Response: no ack and `cmd`=NOP throughout the 20 cycles; ack exactly 1 cycle after `mem_idle` is sampled high.
- Zero inputs:
  - Stimulus: trp=0/trfc=0; separately mask=0.
  - Response: with zero timings, waits are 1 cycle each. With mask=0, ack occurs, no PRE/REF is issued, and the state is back in IDLE after 1 busy cycle.
- Reset mid-REF_WAIT:
  - Stimulus: assert `rst` during REF_WAIT.
  - Response: outputs return to reset values asynchronously; after release, a pending `rfr_req` starts a fresh sequence.
- Macro undefined:
  - Stimulus: same as the basic sequence.
  - Response: REF in cycle 2, no PRECHARGE is ever issued, `rfr_busy` low in cycle 7.
